// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order responses, PC-tagged FIFO to decode.
// Optional IFB_STATS_EN adds empty-cycle and dropped-response counters.
module ifetch_buffer #(
  parameter int          DEPTH           = 4,
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        req_valid_o,
  output logic [63:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  input  logic        instr_ready_i
`ifdef IFB_STATS_EN
  ,
  output logic [31:0] stat_empty_cycles_o,
  output logic [31:0] stat_dropped_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [63:0]   r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_out, r_drop;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_mem_d  [DEPTH];
  logic [63:0]   r_mem_pc [DEPTH];
  logic [31:0]   r_last_d;
  logic [63:0]   r_last_pc;

  logic [63:0]   w_tgt;
  logic [31:0]   w_used;
  logic          w_hs, w_rsp, w_drop_rsp, w_push, w_pop;
  logic [OW-1:0] w_out_nxt;

  assign w_tgt  = redirect_pc_i & ~64'd3;
  // Slots already promised: buffered entries plus responses still expected to land.
  assign w_used = 32'(r_cnt) + 32'(r_out) - 32'(r_drop);

  assign req_valid_o = rst_n && !redirect_i && (32'(r_out) < 32'(MAX_OUTSTANDING))
                       && (w_used < 32'(DEPTH));
  assign req_addr_o  = r_fetch_pc;

  assign w_hs       = req_valid_o && req_ready_i;
  assign w_rsp      = rsp_valid_i && (r_out != '0);
  assign w_drop_rsp = w_rsp && (redirect_i || (r_drop != '0));
  assign w_push     = w_rsp && !w_drop_rsp;
  assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;
  assign w_out_nxt  = r_out + OW'(w_hs) - OW'(w_rsp);

  assign instr_valid_o = (r_cnt != '0);
  assign instr_o       = instr_valid_o ? r_mem_d[r_rptr]  : r_last_d;
  assign pc_o          = instr_valid_o ? r_mem_pc[r_rptr] : r_last_pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wptr]  <= rsp_data_i;
      r_mem_pc[r_wptr] <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_cnt      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_last_d   <= '0;
      r_last_pc  <= '0;
    end else begin
      r_out <= w_out_nxt;
      // Shadow of the visible head so outputs hold once the FIFO empties.
      if (instr_valid_o) begin
        r_last_d  <= r_mem_d[r_rptr];
        r_last_pc <= r_mem_pc[r_rptr];
      end
      if (redirect_i) begin
        r_cnt      <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_fetch_pc <= w_tgt;
        r_rsp_pc   <= w_tgt;
        r_drop     <= w_out_nxt;
      end else begin
        if (w_hs)   r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_push) begin
          r_wptr   <= r_wptr + PW'(1);
          r_rsp_pc <= r_rsp_pc + 64'd4;
        end
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

`ifdef IFB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_empty_cycles_o <= '0;
      stat_dropped_o      <= '0;
    end else begin
      if (!instr_valid_o && instr_ready_i && (stat_empty_cycles_o != 32'hFFFF_FFFF))
        stat_empty_cycles_o <= stat_empty_cycles_o + 32'd1;
      if (w_drop_rsp && (stat_dropped_o != 32'hFFFF_FFFF))
        stat_dropped_o <= stat_dropped_o + 32'd1;
    end
  end
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_i |-> (r_out != '0));
endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer against a queue-based model of fetch, memory and delivery.
module tb_ifetch_buffer;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

  logic        clk, rst_n;
  logic        redirect_i, req_ready_i, rsp_valid_i, instr_ready_i;
  logic [63:0] redirect_pc_i;
  logic [31:0] rsp_data_i;
  logic        req_valid_o, instr_valid_o;
  logic [63:0] req_addr_o, pc_o;
  logic [31:0] instr_o;
`ifdef IFB_STATS_EN
  logic [31:0] stat_empty_cycles_o, stat_dropped_o;
`endif

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i)
`ifdef IFB_STATS_EN
    , .stat_empty_cycles_o(stat_empty_cycles_o), .stat_dropped_o(stat_dropped_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] addr; logic live; } req_t;
  req_t        mq[$];   // requests accepted by memory, in order; live = not killed by redirect
  logic [63:0] fq[$];   // PCs waiting in the queue for decode
  logic [63:0] fpc, lpc;
  logic [31:0] lin;
  int          errs, checks, se, sd;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rd, input logic [63:0] tgt, input logic rr,
                       input logic ir, input bit rspen);
    int live;
    logic exp_rv, hs, rsp, pop;
    req_t e;
    logic [63:0] dummy;
    @(negedge clk);
    redirect_i    = rd;
    redirect_pc_i = tgt;
    req_ready_i   = rr;
    instr_ready_i = ir;
    rsp_valid_i   = rspen && (mq.size() != 0);
    rsp_data_i    = rsp_valid_i ? hash(mq[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (mq[i]) if (mq[i].live) live++;
    exp_rv = !rd && (mq.size() < MAXO) && (fq.size() + live < DEPTH);
    chk("req_valid", req_valid_o, exp_rv);
    if (exp_rv) chk("req_addr", req_addr_o, fpc);
    chk("instr_valid", instr_valid_o, fq.size() != 0);
    if (fq.size() != 0) begin
      lpc = fq[0];
      lin = hash(fq[0]);
    end
    chk("pc", pc_o, lpc);
    chk("instr", instr_o, lin);
`ifdef IFB_STATS_EN
    chk("stat_empty", stat_empty_cycles_o, se);
    chk("stat_dropped", stat_dropped_o, sd);
    if (fq.size() == 0 && ir) se++;
`endif
    hs  = exp_rv && rr;
    rsp = rsp_valid_i;
    pop = (fq.size() != 0) && ir && !rd;
    if (pop) dummy = fq.pop_front();
    if (rsp) begin
      e = mq.pop_front();
      if (e.live && !rd) fq.push_back(e.addr);
      else sd++;
    end
    if (rd) begin
      fq.delete();
      foreach (mq[i]) mq[i].live = 1'b0;
      fpc = tgt & ~64'd3;
    end
    if (hs) begin
      e.addr = fpc;
      e.live = 1'b1;
      mq.push_back(e);
      fpc = fpc + 64'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    redirect_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_instr_valid", instr_valid_o, 1'b0);
    chk("rst_req_addr", req_addr_o, RPC);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 64'd0);
    mq.delete(); fq.delete();
    fpc = RPC; lpc = '0; lin = '0; se = 0; sd = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; instr_ready_i = 1'b0;
    do_reset();
    // streaming with latency 1
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // decode stall: fill, then drain
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // memory stalls request acceptance
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // redirect with two requests in flight
    for (int k = 0; k < 20 && mq.size() < 2; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 64'h0000_0000_8000_0103, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // redirect coinciding with response, pop and stalled request
    for (int k = 0; k < 20 && !(mq.size() == 1 && fq.size() != 0); k++)
      cycle(1'b0, '0, 1'b1, 1'b0, k[0]);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h0000_0000_9000_0040, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // PC wrap at the top of the address space
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // asynchronous reset with buffered entries and one in flight
    for (int k = 0; k < 20 && !(mq.size() == 1 && fq.size() == 3); k++)
      cycle(1'b0, '0, 1'b1, 1'b0, k[0]);
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // random traffic
    for (int k = 0; k < 3000; k++)
      cycle(($urandom_range(0, 15) == 0), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) < 7));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
